// File: rtl/main_control_fsm.sv
// Multi-cycle processor main control unit: Moore FSM sequencing fetch, decode,
// memory, ALU and write-back phases, with registered datapath enables.
module main_control_fsm (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_source,
    output logic [2:0] alu_op,
    output logic       illegal_op,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXECUTE   = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EXEC = 4'd10,
        S_ADDI_WB   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [2:0] ALU_FUNCT = 3'b000;
    localparam logic [2:0] ALU_ADD   = 3'b001;
    localparam logic [2:0] ALU_SUB   = 3'b010;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic [2:0] alu_op;
    } ctrl_t;

    state_t state_q;
    ctrl_t  ctrl_q;
    logic   in_fetch;
    logic   legal_op;

    function automatic state_t next_state(input state_t s, input logic [5:0] op,
                                          input logic rdy);
        state_t n;
        n = S_FETCH;
        case (s)
            S_FETCH:     n = rdy ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_RTYPE:     n = S_EXECUTE;
                    OP_LW, OP_SW: n = S_MEM_ADDR;
                    OP_BEQ:       n = S_BRANCH;
                    OP_J:         n = S_JUMP;
                    OP_ADDI:      n = S_ADDI_EXEC;
                    default:      n = S_FETCH;
                endcase
            end
            S_MEM_ADDR:  n = (op == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ:  n = rdy ? S_MEM_WB : S_MEM_READ;
            S_MEM_WRITE: n = rdy ? S_FETCH : S_MEM_WRITE;
            S_EXECUTE:   n = S_R_WB;
            S_ADDI_EXEC: n = S_ADDI_WB;
            default:     n = S_FETCH;
        endcase
        return n;
    endfunction

    // Fixed per-state enables; the mem_ready-dependent FETCH strobes are added at the output.
    function automatic ctrl_t ctrl_for(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_read  = 1'b1;
                c.alu_src_b = 2'b01;
                c.alu_op    = ALU_ADD;
            end
            S_DECODE: begin
                c.alu_src_b = 2'b11;
                c.alu_op    = ALU_ADD;
            end
            S_MEM_ADDR, S_ADDI_EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
                c.alu_op    = ALU_ADD;
            end
            S_MEM_READ: begin
                c.mem_read = 1'b1;
                c.i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            S_MEM_WRITE: begin
                c.mem_write = 1'b1;
                c.i_or_d    = 1'b1;
            end
            S_EXECUTE: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = ALU_FUNCT;
            end
            S_R_WB: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a     = 1'b1;
                c.alu_op        = ALU_SUB;
                c.pc_write_cond = 1'b1;
                c.pc_source     = 2'b01;
            end
            S_JUMP: begin
                c.pc_write  = 1'b1;
                c.pc_source = 2'b10;
            end
            S_ADDI_WB: c.reg_write = 1'b1;
            default:   c = '0;
        endcase
        return c;
    endfunction

    // NOTE: the enables are registered from the *next* state so they change on the
    // same edge as state_q; non-blocking assignments keep both flops in lockstep.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            ctrl_q  <= ctrl_for(S_FETCH);
        end else begin
            state_q <= next_state(state_q, opcode, mem_ready);
            ctrl_q  <= ctrl_for(next_state(state_q, opcode, mem_ready));
        end
    end

    assign in_fetch = (state_q == S_FETCH);
    assign legal_op = opcode inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI};

    // NOTE: reset is synchronous, so rst_n also masks the outputs directly to keep
    // every enable quiet for the whole time it is held low, not just after the edge.
    assign pc_write      = rst_n & (ctrl_q.pc_write | (in_fetch & mem_ready));
    assign ir_write      = rst_n & in_fetch & mem_ready;
    assign pc_write_cond = rst_n & ctrl_q.pc_write_cond;
    assign i_or_d        = rst_n & ctrl_q.i_or_d;
    assign mem_read      = rst_n & ctrl_q.mem_read;
    assign mem_write     = rst_n & ctrl_q.mem_write;
    assign reg_write     = rst_n & ctrl_q.reg_write;
    assign reg_dst       = rst_n & ctrl_q.reg_dst;
    assign mem_to_reg    = rst_n & ctrl_q.mem_to_reg;
    assign alu_src_a     = rst_n & ctrl_q.alu_src_a;
    assign alu_src_b     = rst_n ? ctrl_q.alu_src_b : 2'b00;
    assign pc_source     = rst_n ? ctrl_q.pc_source : 2'b00;
    assign alu_op        = rst_n ? ctrl_q.alu_op : 3'b000;
    assign illegal_op    = rst_n & (state_q == S_DECODE) & ~legal_op;
    assign state         = rst_n ? state_q : S_FETCH;

endmodule

// File: doc/main_control_fsm.md
MAIN_CONTROL_FSM -- requirements
Module: main_control_fsm

Interface
REQ-001 SHALL provide port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 SHALL provide port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-003 SHALL provide port opcode, input, 6 bits: instruction bits [31:26] from the instruction register.
REQ-004 SHALL provide port mem_ready, input, 1 bit: memory access completes in the cycle it is high.
REQ-005 SHALL provide the datapath enables, each an output of 1 bit: pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, reg_write, reg_dst, mem_to_reg, alu_src_a.
REQ-006 SHALL provide port alu_src_b, output, 2 bits: 00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = shifted sign-extended immediate.
REQ-007 SHALL provide port pc_source, output, 2 bits: 00 = ALU result, 01 = ALUOut, 10 = jump target.
REQ-008 SHALL provide port alu_op, output, 3 bits, driving UC_signal of the ALU control: 000 = decode funct, 001 = add, 010 = subtract.
REQ-009 SHALL provide port illegal_op, output, 1 bit: one-cycle pulse on an unsupported opcode.
REQ-010 SHALL provide port state, output, 4 bits: current state, for debug.

Function
REQ-011 SHALL implement a Moore FSM, except that pc_write and ir_write depend on mem_ready in FETCH.
REQ-012 SHALL use this state encoding: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, EXECUTE=6, R_WB=7, BRANCH=8, JUMP=9, ADDI_EXEC=10, ADDI_WB=11; encodings 12-15 SHALL transition to FETCH.
REQ-013 FETCH SHALL drive mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=001, pc_source=00.
REQ-014 In FETCH, ir_write and pc_write SHALL equal mem_ready; FETCH SHALL go to DECODE when mem_ready=1 and otherwise hold.
REQ-015 DECODE SHALL drive alu_src_a=0, alu_src_b=11, alu_op=001, and SHALL branch on opcode as follows.
- 000000 -> EXECUTE
- 100011 or 101011 -> MEM_ADDR
- 000100 -> BRANCH
- 000010 -> JUMP
- 001000 -> ADDI_EXEC
- any other opcode -> FETCH, with illegal_op=1 for that cycle.
REQ-016 MEM_ADDR SHALL drive alu_src_a=1, alu_src_b=10, alu_op=001, then go to MEM_READ if opcode=100011 and otherwise to MEM_WRITE.
REQ-017 MEM_READ SHALL drive mem_read=1, i_or_d=1, hold until mem_ready=1, then go to MEM_WB.
REQ-018 MEM_WB SHALL drive reg_write=1, reg_dst=0, mem_to_reg=1, then go to FETCH.
REQ-019 MEM_WRITE SHALL drive mem_write=1, i_or_d=1, hold until mem_ready=1, then go to FETCH.
REQ-020 EXECUTE SHALL drive alu_src_a=1, alu_src_b=00, alu_op=000, then go to R_WB.
REQ-021 R_WB SHALL drive reg_write=1, reg_dst=1, mem_to_reg=0, then go to FETCH.
REQ-022 BRANCH SHALL drive alu_src_a=1, alu_src_b=00, alu_op=010, pc_write_cond=1, pc_source=01, then go to FETCH.
REQ-023 JUMP SHALL drive pc_write=1, pc_source=10, then go to FETCH.
REQ-024 ADDI_EXEC SHALL drive alu_src_a=1, alu_src_b=10, alu_op=001, then go to ADDI_WB.
REQ-025 ADDI_WB SHALL drive reg_write=1, reg_dst=0, mem_to_reg=0, then go to FETCH.
REQ-026 Any output not listed for a state SHALL be 0.
REQ-027 Opcode SHALL be sampled only in DECODE and MEM_ADDR; opcode changes in other states SHALL have no effect.
REQ-028 Cycle counts with mem_ready held at 1 SHALL be:
- lw: 5
- sw: 4
- R-type: 4
- addi: 4
- beq: 3
- j: 3
REQ-029 Each wait cycle with mem_ready=0 in FETCH, MEM_READ or MEM_WRITE SHALL add exactly one cycle, with outputs stable.

Reset
REQ-030 When rst_n is sampled low at a rising clk edge, state SHALL become FETCH, from any state including mid-wait.
REQ-031 While rst_n is low, pc_write, pc_write_cond, mem_read, mem_write, ir_write, reg_write and illegal_op SHALL be 0, and all other outputs SHALL be 0.
REQ-032 The first FETCH with mem_read=1 SHALL occur in the first cycle with rst_n high.

Verification
REQ-033 Reset, then opcode=100011 with mem_ready=1 -> state sequence 0,1,2,3,4,0; reg_write=1 and mem_to_reg=1 only in state 4.
REQ-034 opcode=000000 -> states 0,1,6,7,0; alu_op=000 in state 6; reg_dst=1 and reg_write=1 in state 7.
REQ-035 opcode=000100 -> states 0,1,8,0; alu_op=010, pc_write_cond=1, pc_source=01 in state 8. opcode=000010 -> state 9 with pc_write=1, pc_source=10.
REQ-036 opcode=101011 with mem_ready low for 3 cycles in MEM_WRITE -> state 5 held for 4 cycles with mem_write=1, then 0; in FETCH with mem_ready=0, pc_write=0 and ir_write=0.
REQ-037 opcode=111111 in DECODE -> illegal_op=1 for exactly one cycle, next state 0, no write enable asserted.
REQ-038 rst_n driven low while in MEM_READ -> next state 0, all enables 0 during reset; after release, FETCH with mem_read=1.
